// File: rtl/uart1_pkg.sv
// Shared UART1 definitions: framing state encoding, idle line levels and counter sizing.
package uart1_pkg;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    STOP,
    GAP
  } state_t;

  localparam logic START_IDLE = 1'b1;
  localparam logic STOP_IDLE  = 1'b0;

  localparam int unsigned DEF_CLKS_PER_BIT = 2;

  // Width needed to count 0..n-1, never narrower than one bit.
  function automatic int unsigned cnt_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/uart1_bit_timer.sv
// Bit-period tick generator: bit_tick is high on every CLKS_PER_BIT-th cycle after a clear.
module uart1_bit_timer
  import uart1_pkg::*;
#(
  parameter int unsigned CLKS_PER_BIT = DEF_CLKS_PER_BIT
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  output logic bit_tick
);

  localparam int unsigned CW = cnt_width(CLKS_PER_BIT);

  logic [CW-1:0] cnt;

  assign bit_tick = (cnt == CW'(CLKS_PER_BIT - 1));

  always_ff @(posedge clk) begin
    if (!rst || clear || bit_tick) cnt <= '0;
    else                           cnt <= cnt + CW'(1);
  end

endmodule

// File: rtl/uart1_tx_arbiter.sv
// Round-robin arbiter sharing one UART1 transmitter between two byte requesters;
// sequences start/data/stop framing and an inter-frame gap for each granted byte.
module uart1_tx_arbiter
  import uart1_pkg::*;
#(
  parameter int unsigned CLKS_PER_BIT = DEF_CLKS_PER_BIT,
  parameter int unsigned DATA_BITS    = 8,
  parameter int unsigned GAP_CYCLES   = 2
) (
  input  logic                 clk_sis,
  input  logic                 rst,
  input  logic                 req0_valid,
  input  logic [DATA_BITS-1:0] req0_data,
  output logic                 req0_ready,
  input  logic                 req1_valid,
  input  logic [DATA_BITS-1:0] req1_data,
  output logic                 req1_ready,
  output logic                 start_bit,
  output logic [DATA_BITS-1:0] data_in,
  output logic                 stop_bit,
  output logic                 busy,
  output logic [1:0]           grant
);

  // The IDLE cycle in which the next byte is accepted supplies the last gap
  // cycle, so GAP itself lasts one cycle less and frames repeat every
  // (DATA_BITS+2)*CLKS_PER_BIT + GAP_CYCLES cycles.
  localparam int unsigned GAP_HOLD = (GAP_CYCLES > 1) ? GAP_CYCLES - 1 : 0;
  localparam int unsigned GAP_LAST = (GAP_HOLD > 0) ? GAP_HOLD - 1 : 0;
  localparam int unsigned BW       = cnt_width(DATA_BITS);
  localparam int unsigned GW       = cnt_width((GAP_HOLD > 0) ? GAP_HOLD : 1);

  state_t               state, state_next;
  logic [DATA_BITS-1:0] data_q;
  logic [BW-1:0]        bit_cnt;
  logic [GW-1:0]        gap_cnt;
  logic                 rr_last;
  logic                 sel0, sel1, take;
  logic                 bit_tick, timer_clear;
  logic                 start_next, stop_next, busy_next;
  logic [DATA_BITS-1:0] data_next;

  always_comb begin
    sel0       = req0_valid && (!req1_valid || rr_last);
    sel1       = req1_valid && (!req0_valid || !rr_last);
    req0_ready = rst && (state == IDLE) && sel0;
    req1_ready = rst && (state == IDLE) && sel1;
    take       = req0_ready || req1_ready;
  end

  always_comb begin
    state_next = state;
    unique case (state)
      IDLE:    if (take) state_next = START;
      START:   if (bit_tick) state_next = DATA;
      DATA:    if (bit_tick && (bit_cnt == BW'(DATA_BITS - 1))) state_next = STOP;
      STOP:    if (bit_tick) state_next = (GAP_HOLD == 0) ? IDLE : GAP;
      GAP:     if (gap_cnt == GW'(GAP_LAST)) state_next = IDLE;
      default: state_next = IDLE;
    endcase

    start_next = (state_next == START) ? ~START_IDLE : START_IDLE;
    stop_next  = (state_next == STOP)  ? ~STOP_IDLE  : STOP_IDLE;
    data_next  = (state_next == DATA)  ? data_q      : '0;
    busy_next  = (state_next != IDLE);
  end

  assign timer_clear = (state_next != state) || (state == IDLE);

  uart1_bit_timer #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_bit_timer (
    .clk      (clk_sis),
    .rst      (rst),
    .clear    (timer_clear),
    .bit_tick (bit_tick)
  );

  always_ff @(posedge clk_sis) begin
    if (!rst) state <= IDLE;
    else      state <= state_next;
  end

  always_ff @(posedge clk_sis) begin
    if (!rst) begin
      data_q    <= '0;
      bit_cnt   <= '0;
      gap_cnt   <= '0;
      rr_last   <= 1'b1;
      grant     <= '0;
      start_bit <= START_IDLE;
      data_in   <= '0;
      stop_bit  <= STOP_IDLE;
      busy      <= 1'b0;
    end else begin
      if (take) begin
        data_q  <= req1_ready ? req1_data : req0_data;
        rr_last <= req1_ready;
        grant   <= {req1_ready, req0_ready};
      end else if (state_next == IDLE) begin
        grant   <= '0;
      end

      if (state_next != state)            bit_cnt <= '0;
      else if (state == DATA && bit_tick) bit_cnt <= bit_cnt + BW'(1);

      if (state_next != state) gap_cnt <= '0;
      else if (state == GAP)   gap_cnt <= gap_cnt + GW'(1);

      start_bit <= start_next;
      data_in   <= data_next;
      stop_bit  <= stop_next;
      busy      <= busy_next;
    end
  end

endmodule
